// File: rtl/regfile_mp.sv
// Multi-port register file with write-back scoreboard.
// Two read ports, two write ports, optional bypass, zero reg and read register.
module regfile_mp #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int RESET_BASE   = 5,
    parameter int ZERO_REG     = 0,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en0,
    input  logic [ADDR_W-1:0]       rd_addr0,
    output logic [DATA_W-1:0]       rd_data0,
    output logic                    rd_valid0,
    input  logic                    rd_en1,
    input  logic [ADDR_W-1:0]       rd_addr1,
    output logic [DATA_W-1:0]       rd_data1,
    output logic                    rd_valid1,
    input  logic                    wr_en0,
    input  logic [ADDR_W-1:0]       wr_addr0,
    input  logic [DATA_W-1:0]       wr_data0,
    input  logic                    wr_en1,
    input  logic [ADDR_W-1:0]       wr_addr1,
    input  logic [DATA_W-1:0]       wr_data1,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic [(2**ADDR_W)-1:0]  busy,
    output logic                    rsv_stall,
    output logic                    wr_collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              coll_q;
    logic              coll_d;
    logic              wr_ok0;
    logic              wr_ok1;
    logic [DATA_W-1:0] rd_data0_d;
    logic [DATA_W-1:0] rd_data1_d;

    function automatic logic [DATA_W-1:0] reset_val(input int i);
        if (ZERO_REG != 0 && i == 0) begin
            return '0;
        end
        return DATA_W'(RESET_BASE + i);
    endfunction

    function automatic logic [DATA_W-1:0] read_sel(
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] arr_val,
        input logic              ok0,
        input logic [ADDR_W-1:0] waddr0,
        input logic [DATA_W-1:0] wdata0,
        input logic              ok1,
        input logic [ADDR_W-1:0] waddr1,
        input logic [DATA_W-1:0] wdata1
    );
        if (!en) begin
            return '0;
        end
        if (BYPASS != 0 && ok1 && waddr1 == addr) begin
            return wdata1;
        end
        if (BYPASS != 0 && ok0 && waddr0 == addr) begin
            return wdata0;
        end
        return arr_val;
    endfunction

    // Writes to the hardwired zero register never take effect
    always_comb begin
        wr_ok0 = wr_en0 && !(ZERO_REG != 0 && wr_addr0 == '0);
        wr_ok1 = wr_en1 && !(ZERO_REG != 0 && wr_addr1 == '0);
    end

    // Next array contents; port 1 is applied last so it wins on a clash
    always_comb begin
        regs_d = regs_q;
        if (wr_ok0) regs_d[wr_addr0] = wr_data0;
        if (wr_ok1) regs_d[wr_addr1] = wr_data1;
    end

    // Scoreboard: releases first, then a reservation re-marks the entry
    always_comb begin
        busy_d = busy_q;
        if (wr_en0) busy_d[wr_addr0] = 1'b0;
        if (wr_en1) busy_d[wr_addr1] = 1'b0;
        if (rsv_en) busy_d[rsv_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
        coll_d = wr_en0 && wr_en1 && (wr_addr0 == wr_addr1);
    end

    // Selected read values, with optional same-cycle write forwarding
    always_comb begin
        rd_data0_d = read_sel(rd_en0, rd_addr0, regs_q[rd_addr0],
                              wr_ok0, wr_addr0, wr_data0,
                              wr_ok1, wr_addr1, wr_data1);
        rd_data1_d = read_sel(rd_en1, rd_addr1, regs_q[rd_addr1],
                              wr_ok0, wr_addr0, wr_data0,
                              wr_ok1, wr_addr1, wr_data1);
    end

    // Array, scoreboard and collision flag state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= reset_val(i);
            end
            busy_q <= '0;
            coll_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            coll_q <= coll_d;
        end
    end

    assign busy         = busy_q;
    assign rsv_stall    = rsv_en & busy_q[rsv_addr];
    assign wr_collision = coll_q;

    generate
        if (READ_LATENCY != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd_data0_q;
            logic [DATA_W-1:0] rd_data1_q;
            logic              rd_valid0_q;
            logic              rd_valid1_q;

            // Registered read path: capture the selected value each edge
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data0_q  <= '0;
                    rd_data1_q  <= '0;
                    rd_valid0_q <= 1'b0;
                    rd_valid1_q <= 1'b0;
                end else begin
                    rd_data0_q  <= rd_data0_d;
                    rd_data1_q  <= rd_data1_d;
                    rd_valid0_q <= rd_en0;
                    rd_valid1_q <= rd_en1;
                end
            end

            assign rd_data0  = rd_data0_q;
            assign rd_data1  = rd_data1_q;
            assign rd_valid0 = rd_valid0_q;
            assign rd_valid1 = rd_valid1_q;
        end else begin : g_rd_comb
            assign rd_data0  = rd_data0_d;
            assign rd_data1  = rd_data1_d;
            assign rd_valid0 = rd_en0;
            assign rd_valid1 = rd_en1;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations driven by shared stimulus.
// Directed steps then random traffic against an array-based model.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        rd_en0, rd_en1;
    logic [3:0]  rd_addr0, rd_addr1;
    logic        wr_en0, wr_en1;
    logic [3:0]  wr_addr0, wr_addr1;
    logic [15:0] wr_data0, wr_data1;
    logic        rsv_en;
    logic [3:0]  rsv_addr;

    logic [15:0] a_rd_data0, a_rd_data1, b_rd_data0, b_rd_data1;
    logic        a_rd_valid0, a_rd_valid1, b_rd_valid0, b_rd_valid1;
    logic [15:0] a_busy, b_busy;
    logic        a_rsv_stall, b_rsv_stall;
    logic        a_wr_collision, b_wr_collision;

    int checks = 0;
    int errors = 0;

    // Model state: A = combinational read, bypass on, no zero register
    //              B = registered read, bypass off, zero register
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    logic [15:0] busy_a, busy_b;
    logic        coll_m;
    logic [15:0] rdq_b0, rdq_b1;
    logic        rv_b0, rv_b1;

    regfile_mp #(
        .DATA_W(16), .ADDR_W(4), .RESET_BASE(5),
        .ZERO_REG(0), .BYPASS(1), .READ_LATENCY(0)
    ) u_a (
        .clk(clk), .reset(reset),
        .rd_en0(rd_en0), .rd_addr0(rd_addr0),
        .rd_data0(a_rd_data0), .rd_valid0(a_rd_valid0),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1),
        .rd_data1(a_rd_data1), .rd_valid1(a_rd_valid1),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy(a_busy), .rsv_stall(a_rsv_stall),
        .wr_collision(a_wr_collision)
    );

    regfile_mp #(
        .DATA_W(16), .ADDR_W(4), .RESET_BASE(5),
        .ZERO_REG(1), .BYPASS(0), .READ_LATENCY(1)
    ) u_b (
        .clk(clk), .reset(reset),
        .rd_en0(rd_en0), .rd_addr0(rd_addr0),
        .rd_data0(b_rd_data0), .rd_valid0(b_rd_valid0),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1),
        .rd_data1(b_rd_data1), .rd_valid1(b_rd_valid1),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy(b_busy), .rsv_stall(b_rsv_stall),
        .wr_collision(b_wr_collision)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 16'(5 + i);
            mem_b[i] = (i == 0) ? 16'h0000 : 16'(5 + i);
        end
        busy_a = '0;
        busy_b = '0;
        coll_m = 1'b0;
        rdq_b0 = '0;
        rdq_b1 = '0;
        rv_b0  = 1'b0;
        rv_b1  = 1'b0;
    endtask

    function automatic logic [15:0] exp_a(input logic en, input logic [3:0] ad);
        if (!en) return 16'h0000;
        if (wr_en1 && wr_addr1 == ad) return wr_data1;
        if (wr_en0 && wr_addr0 == ad) return wr_data0;
        return mem_a[ad];
    endfunction

    function automatic logic [15:0] val_b(input logic en, input logic [3:0] ad);
        if (!en || ad == 4'd0) return 16'h0000;
        return mem_b[ad];
    endfunction

    task automatic check_all();
        chk("a_rd_data0", a_rd_data0, exp_a(rd_en0, rd_addr0));
        chk("a_rd_data1", a_rd_data1, exp_a(rd_en1, rd_addr1));
        chk("a_rd_valid0", a_rd_valid0, rd_en0);
        chk("a_rd_valid1", a_rd_valid1, rd_en1);
        chk("a_busy", a_busy, busy_a);
        chk("a_rsv_stall", a_rsv_stall, rsv_en & busy_a[rsv_addr]);
        chk("a_wr_collision", a_wr_collision, coll_m);
        chk("b_rd_data0", b_rd_data0, rdq_b0);
        chk("b_rd_data1", b_rd_data1, rdq_b1);
        chk("b_rd_valid0", b_rd_valid0, rv_b0);
        chk("b_rd_valid1", b_rd_valid1, rv_b1);
        chk("b_busy", b_busy, busy_b);
        chk("b_rsv_stall", b_rsv_stall, rsv_en & busy_b[rsv_addr]);
        chk("b_wr_collision", b_wr_collision, coll_m);
    endtask

    // Check current outputs, then advance one clock and update the model
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        rdq_b0 = val_b(rd_en0, rd_addr0);
        rdq_b1 = val_b(rd_en1, rd_addr1);
        rv_b0  = rd_en0;
        rv_b1  = rd_en1;
        if (wr_en0) mem_a[wr_addr0] = wr_data0;
        if (wr_en1) mem_a[wr_addr1] = wr_data1;
        if (wr_en0 && wr_addr0 != 4'd0) mem_b[wr_addr0] = wr_data0;
        if (wr_en1 && wr_addr1 != 4'd0) mem_b[wr_addr1] = wr_data1;
        if (wr_en0) begin
            busy_a[wr_addr0] = 1'b0;
            busy_b[wr_addr0] = 1'b0;
        end
        if (wr_en1) begin
            busy_a[wr_addr1] = 1'b0;
            busy_b[wr_addr1] = 1'b0;
        end
        if (rsv_en) begin
            busy_a[rsv_addr] = 1'b1;
            busy_b[rsv_addr] = 1'b1;
        end
        busy_b[0] = 1'b0;
        coll_m = wr_en0 && wr_en1 && wr_addr0 == wr_addr1;
        @(negedge clk);
    endtask

    task automatic idle();
        rd_en0 = 0; rd_addr0 = 0; rd_en1 = 0; rd_addr1 = 0;
        wr_en0 = 0; wr_addr0 = 0; wr_data0 = 0;
        wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0;
        rsv_en = 0; rsv_addr = 0;
    endtask

    function automatic logic [3:0] rnd_addr();
        if ($urandom_range(0, 1) == 1) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        idle();
        reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_a_busy", a_busy, 16'h0000);
        chk("rst_b_rd_valid0", b_rd_valid0, 1'b0);
        chk("rst_b_rd_data0", b_rd_data0, 16'h0000);
        check_all();
        reset = 1'b0;

        // Reset values through the combinational port
        idle(); rd_en0 = 1; rd_addr0 = 3;
        #1 chk("t1_addr3", a_rd_data0, 16'h0008);
        cycle();
        idle(); rd_en0 = 1; rd_addr0 = 15;
        #1 chk("t1_addr15", a_rd_data0, 16'h0014);
        cycle();

        // Same-cycle write then read
        idle(); wr_en0 = 1; wr_addr0 = 7; wr_data0 = 16'hBEEF;
        rd_en1 = 1; rd_addr1 = 7;
        #1 chk("t2_bypass", a_rd_data1, 16'hBEEF);
        cycle();
        idle(); rd_en1 = 1; rd_addr1 = 7;
        #1 chk("t2_b_old", b_rd_data1, 16'h000C);
        chk("t2_a_after", a_rd_data1, 16'hBEEF);
        cycle();
        idle();
        #1 chk("t2_b_new", b_rd_data1, 16'hBEEF);
        cycle();

        // Write collision
        idle(); wr_en0 = 1; wr_en1 = 1; wr_addr0 = 2; wr_addr1 = 2;
        wr_data0 = 16'h1111; wr_data1 = 16'h2222;
        cycle();
        idle(); rd_en0 = 1; rd_addr0 = 2;
        #1 chk("t3_coll", a_wr_collision, 1'b1);
        chk("t3_port1_wins", a_rd_data0, 16'h2222);
        cycle();
        idle();
        #1 chk("t3_coll_pulse", a_wr_collision, 1'b0);
        cycle();

        // Scoreboard reserve / stall / release
        idle(); rsv_en = 1; rsv_addr = 5;
        cycle();
        idle(); rsv_en = 1; rsv_addr = 5;
        #1 chk("t4_busy5", a_busy[5], 1'b1);
        chk("t4_stall", a_rsv_stall, 1'b1);
        cycle();
        idle(); wr_en1 = 1; wr_addr1 = 5; wr_data1 = 16'h0055;
        rsv_en = 1; rsv_addr = 5;
        cycle();
        idle();
        #1 chk("t4_rsv_wins", a_busy[5], 1'b1);
        wr_en0 = 1; wr_addr0 = 5; wr_data0 = 16'h0505;
        cycle();
        idle();
        #1 chk("t4_release", a_busy[5], 1'b0);
        cycle();

        // Registered read latency and zero register
        idle(); rd_en0 = 1; rd_addr0 = 4;
        cycle();
        idle();
        #1 chk("t5_valid", b_rd_valid0, 1'b1);
        chk("t5_data", b_rd_data0, 16'h0009);
        cycle();
        idle();
        #1 chk("t5_valid_drop", b_rd_valid0, 1'b0);
        chk("t5_data_zero", b_rd_data0, 16'h0000);
        cycle();
        idle(); wr_en0 = 1; wr_addr0 = 0; wr_data0 = 16'hFFFF;
        rsv_en = 1; rsv_addr = 0;
        cycle();
        idle(); rd_en0 = 1; rd_addr0 = 0;
        #1 chk("t5_b_busy0", b_busy[0], 1'b0);
        chk("t5_a_busy0", a_busy[0], 1'b1);
        cycle();
        idle();
        #1 chk("t5_b_zero", b_rd_data0, 16'h0000);
        cycle();

        // Mid-operation asynchronous reset
        idle(); rsv_en = 1; rsv_addr = 4;
        wr_en0 = 1; wr_addr0 = 0; wr_data0 = 16'h1234;
        cycle();
        idle(); rsv_en = 1; rsv_addr = 5;
        cycle();
        idle(); rsv_en = 1; rsv_addr = 6;
        cycle();
        idle(); rsv_en = 1; rsv_addr = 7; rd_en1 = 1; rd_addr1 = 3;
        wr_en0 = 1; wr_en1 = 1; wr_addr0 = 1; wr_addr1 = 1;
        wr_data0 = 16'hAAAA; wr_data1 = 16'h5555;
        cycle();
        idle();
        #1 chk("t6_busy_pre", a_busy, 16'h00F0);
        chk("t6_coll_pre", a_wr_collision, 1'b1);
        chk("t6_valid_pre", b_rd_valid1, 1'b1);
        reset = 1'b1;
        model_reset();
        rd_en0 = 1; rd_addr0 = 1;
        #1 chk("t6_busy", a_busy, 16'h0000);
        chk("t6_coll", a_wr_collision, 1'b0);
        chk("t6_reg1", a_rd_data0, 16'h0006);
        chk("t6_b_valid", b_rd_valid1, 1'b0);
        check_all();
        reset = 1'b0;
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rd_en0   = 1'($urandom_range(0, 1));
            rd_addr0 = rnd_addr();
            rd_en1   = 1'($urandom_range(0, 1));
            rd_addr1 = rnd_addr();
            wr_en0   = 1'($urandom_range(0, 1));
            wr_addr0 = rnd_addr();
            wr_data0 = 16'($urandom);
            wr_en1   = 1'($urandom_range(0, 1));
            wr_addr1 = rnd_addr();
            wr_data1 = 16'($urandom);
            rsv_en   = 1'($urandom_range(0, 1));
            rsv_addr = rnd_addr();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
